sc_window_sequencer: RTL and testbench

SC_WINDOW_SEQUENCER -- requirements
Module: sc_window_sequencer

---
 rtl/sc_window_sequencer_if.sv | 32 +++
 rtl/sc_window_sequencer.sv | 131 +++++++++++++
 tb/tb_sc_window_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_window_sequencer_if.sv
// Control/data bundle between the window sequencer and its environment.
// The sequencer takes the slave modport; a driver or test harness takes master.
interface sc_window_sequencer_if #(
  parameter int VAL_W    = 9,
  parameter int WIN_LOG2 = 17
) ();
  logic                start;
  logic                abort;
  logic                ser_a;
  logic                ser_b;
  logic [VAL_W-1:0]    op_a;
  logic [VAL_W-1:0]    op_b;
  logic                lfsr_en;
  logic                acc_clr;
  logic                acc_en;
  logic                res_latch;
  logic                busy;
  logic                done;
  logic [WIN_LOG2-1:0] win_cnt;

  // start/abort are level-sampled requests on each rising edge; there is no
  // ready return: start is accepted only in IDLE, abort only outside IDLE.
  modport master (
    output start, abort, ser_a, ser_b,
    input  op_a, op_b, lfsr_en, acc_clr, acc_en, res_latch, busy, done, win_cnt
  );

  modport slave (
    input  start, abort, ser_a, ser_b,
    output op_a, op_b, lfsr_en, acc_clr, acc_en, res_latch, busy, done, win_cnt
  );
endinterface

// File: rtl/sc_window_sequencer.sv
// Load-then-evaluate sequencer for a stochastic-computing window.
// Optional macro SC_SEQ_CONTINUOUS_EN: DONE restarts LOAD without a new start.
module sc_window_sequencer #(
  parameter int WIN_LOG2   = 17,
  parameter int FRAME_BITS = 10,
  parameter int VAL_W      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sc_window_sequencer_if.slave  bus,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int                  BC_W     = $clog2(FRAME_BITS + 1);
  localparam logic [BC_W-1:0]     BC_LAST  = BC_W'(FRAME_BITS - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_a_q, sr_a_d;
  logic [FRAME_BITS-1:0] sr_b_q, sr_b_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
  logic [VAL_W-1:0]      op_a_q, op_a_d;
  logic [VAL_W-1:0]      op_b_q, op_b_d;
  logic                  lfsr_en_q, acc_clr_q, acc_en_q, res_latch_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start && !bus.abort) state_d = S_LOAD;
      S_LOAD:  if (bit_cnt_q == BC_LAST) state_d = S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (win_cnt_q == WIN_LAST) state_d = S_LATCH;
      S_LATCH: state_d = S_DONE;
`ifdef SC_SEQ_CONTINUOUS_EN
      S_DONE:  state_d = S_LOAD;
`else
      S_DONE:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    // Abort wins over start, end-of-frame and terminal count alike.
    if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    sr_a_d    = sr_a_q;
    sr_b_d    = sr_b_q;
    bit_cnt_d = '0;
    win_cnt_d = win_cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    if (state_q == S_LOAD) begin
      sr_a_d    = {bus.ser_a, sr_a_q[FRAME_BITS-1:1]};
      sr_b_d    = {bus.ser_b, sr_b_q[FRAME_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + BC_W'(1);
    end
    // Operands are captured from the just-completed frame so they are valid
    // throughout ARM; the top (buffer) bit of the frame is dropped.
    if (state_d == S_ARM) begin
      op_a_d    = sr_a_d[VAL_W-1:0];
      op_b_d    = sr_b_d[VAL_W-1:0];
      win_cnt_d = '0;
    end else if (state_q == S_RUN && state_d == S_RUN) begin
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      sr_a_q      <= '0;
      sr_b_q      <= '0;
      bit_cnt_q   <= '0;
      win_cnt_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      lfsr_en_q   <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      res_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_a_q      <= sr_a_d;
      sr_b_q      <= sr_b_d;
      bit_cnt_q   <= bit_cnt_d;
      win_cnt_q   <= win_cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      // Moore outputs decoded from the next state so they line up with state_q.
      lfsr_en_q   <= (state_d == S_RUN);
      acc_clr_q   <= (state_d == S_ARM);
      acc_en_q    <= (state_d == S_RUN);
      res_latch_q <= (state_d == S_LATCH);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.lfsr_en   = lfsr_en_q;
  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.res_latch = res_latch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.win_cnt   = win_cnt_q;
  assign dbg_state_o   = state_q;

  a_busy_matches_state: assert property (@(posedge clk) disable iff (rst_n)
    busy_q == (state_q != S_IDLE));
  a_latch_then_done: assert property (@(posedge clk) disable iff (rst_n)
    res_latch_q |=> (done_q || !busy_q));
  a_arm_then_run: assert property (@(posedge clk) disable iff (rst_n)
    acc_clr_q |=> (acc_en_q || !busy_q));
  a_done_single: assert property (@(posedge clk) disable iff (rst_n)
    done_q |=> !done_q);

endmodule

// File: tb/tb_sc_window_sequencer.sv
// Scoreboard bench for sc_window_sequencer at WIN_LOG2=4; the continuous-mode
// plan is selected when SC_SEQ_CONTINUOUS_EN is defined.
module tb_sc_window_sequencer;
  localparam int WIN_LOG2   = 4;
  localparam int FRAME_BITS = 10;
  localparam int VAL_W      = 9;
  localparam int SEQ_LAT    = FRAME_BITS + (1 << WIN_LOG2) + 3;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  int         cyc;
  int         acc_en_cnt, lfsr_cnt, clr_cnt, latch_cnt, done_cnt;
  logic [2*VAL_W-1:0] exp_q[$];
  int                 done_exp_q[$];

  sc_window_sequencer_if #(.VAL_W(VAL_W), .WIN_LOG2(WIN_LOG2)) bus ();

  sc_window_sequencer #(
    .WIN_LOG2(WIN_LOG2), .FRAME_BITS(FRAME_BITS), .VAL_W(VAL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_op_a"}, 32'(bus.op_a), 0);
    check_eq({pfx, "_op_b"}, 32'(bus.op_b), 0);
    check_eq({pfx, "_lfsr_en"}, 32'(bus.lfsr_en), 0);
    check_eq({pfx, "_acc_clr"}, 32'(bus.acc_clr), 0);
    check_eq({pfx, "_acc_en"}, 32'(bus.acc_en), 0);
    check_eq({pfx, "_res_latch"}, 32'(bus.res_latch), 0);
    check_eq({pfx, "_busy"}, 32'(bus.busy), 0);
    check_eq({pfx, "_done"}, 32'(bus.done), 0);
    check_eq({pfx, "_win_cnt"}, 32'(bus.win_cnt), 0);
    check_eq({pfx, "_state"}, 32'(dbg_state), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      if (bus.acc_en)    acc_en_cnt++;
      if (bus.lfsr_en)   lfsr_cnt++;
      if (bus.res_latch) latch_cnt++;
      if (bus.acc_clr) begin
        clr_cnt++;
        if (exp_q.size() == 0) check_eq("arm_unexpected", 1, 0);
        else begin
          check_eq("arm_ops", 32'({bus.op_b, bus.op_a}), 32'(exp_q.pop_front()));
          check_eq("arm_win_cnt", 32'(bus.win_cnt), 0);
        end
      end
      if (bus.done) begin
        done_cnt++;
        // done is raised by the edge at cyc and first sampled on edge cyc+1.
        if (done_exp_q.size() == 0) check_eq("done_unexpected", 1, 0);
        else check_eq("done_latency_edge", cyc + 1, done_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Pulse start, then stream nbits frame bits LSB first; only a full frame
  // is expected to produce ARM and done.
  task automatic start_seq(input logic [9:0] fa, input logic [9:0] fb, input int nbits);
    int sc;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    sc = cyc;
    bus.start = 1'b0;
    if (nbits == FRAME_BITS) begin
      exp_q.push_back({fb[VAL_W-1:0], fa[VAL_W-1:0]});
      done_exp_q.push_back(sc + SEQ_LAT);
    end
    for (int i = 0; i < nbits; i++) begin
      bus.ser_a = fa[i];
      bus.ser_b = fb[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int seen;
    bit got;
    seen = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt != seen) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check_eq("done_timeout", 0, 1);
  endtask

  task automatic clear_counts();
    acc_en_cnt = 0; lfsr_cnt = 0; clr_cnt = 0; latch_cnt = 0; done_cnt = 0;
  endtask

  // ---------------- test plans ----------------
`ifndef SC_SEQ_CONTINUOUS_EN
  task automatic run_plan();
    logic [9:0] fa, fb;
    int latch0, done0;
    bit hit;

    // Directed stream 1,0,1,1,0,0,0,0,1,x -> op_a = 9'h10D.
    clear_counts();
    start_seq(10'h30D, 10'h0A5, FRAME_BITS);
    wait_done();
    check_eq("cnt_acc_en", acc_en_cnt, 16);
    check_eq("cnt_lfsr_en", lfsr_cnt, 16);
    check_eq("cnt_acc_clr", clr_cnt, 1);
    check_eq("cnt_res_latch", latch_cnt, 1);
    check_eq("cnt_done", done_cnt, 1);
    #1;
    check_eq("idle_after_done_busy", 32'(bus.busy), 0);
    check_eq("hold_op_a", 32'(bus.op_a), 32'h10D);

    // Random frames, with a start pulse during RUN that must be ignored.
    for (int k = 0; k < 3; k++) begin
      fa = 10'($urandom_range(0, 1023));
      fb = 10'($urandom_range(0, 1023));
      start_seq(fa, fb, FRAME_BITS);
      if (k == 1) begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.lfsr_en) break;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_done();
      repeat (4) @(posedge clk);
      #1;
      check_eq("idle_after_seq_state", 32'(dbg_state), 0);
    end

    // start together with abort in IDLE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    check_eq("start_abort_busy", 32'(bus.busy), 0);
    check_eq("start_abort_state", 32'(dbg_state), 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;

    // Abort in RUN at win_cnt=7.
    fa = 10'h155;
    fb = 10'h0F0;
    start_seq(fa, fb, FRAME_BITS);
    hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.lfsr_en && bus.win_cnt == 7) begin
        hit = 1'b1;
        break;
      end
    end
    check_eq("abort_reach_win7", 32'(hit), 1);
    latch0 = latch_cnt;
    done0  = done_cnt;
    bus.abort = 1'b1;
    void'(done_exp_q.pop_back());
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 0);
    check_eq("abort_state", 32'(dbg_state), 0);
    check_eq("abort_res_latch", 32'(bus.res_latch), 0);
    check_eq("abort_op_a", 32'(bus.op_a), 32'(fa[VAL_W-1:0]));
    check_eq("abort_op_b", 32'(bus.op_b), 32'(fb[VAL_W-1:0]));
    check_eq("abort_win_cnt_hold", 32'(bus.win_cnt), 7);
    repeat (40) @(posedge clk);
    check_eq("abort_no_latch", latch_cnt, latch0);
    check_eq("abort_no_done", done_cnt, done0);

    // Reset in the middle of LOAD, then a full sequence.
    start_seq(10'h3FF, 10'h3FF, 4);
    rst_n = 1'b1;
    #1;
    check_all_zero("midload_rst");
    exp_q.delete();
    done_exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_wait_busy", 32'(bus.busy), 0);
    clear_counts();
    start_seq(10'h2C3, 10'h11E, FRAME_BITS);
    wait_done();
    check_eq("post_rst_cnt_acc_en", acc_en_cnt, 16);
    check_eq("post_rst_cnt_done", done_cnt, 1);
  endtask
`else
  task automatic run_plan();
    int s;
    clear_counts();
    start_seq(10'h3FF, 10'h000, FRAME_BITS);
    // Streams stay at 1/0, so every repeated frame loads the same operands.
    s = done_exp_q[0];
    for (int k = 1; k < 3; k++) begin
      exp_q.push_back({9'h000, 9'h1FF});
      done_exp_q.push_back(s + k * SEQ_LAT);
    end
    for (int k = 0; k < 3; k++) wait_done();
    check_eq("cont_done_cnt", done_cnt, 3);
    check_eq("cont_acc_en", acc_en_cnt, 48);
    check_eq("cont_res_latch", latch_cnt, 3);
    #1;
    check_eq("cont_reload_busy", 32'(bus.busy), 1);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check_eq("cont_abort_busy", 32'(bus.busy), 0);
    check_eq("cont_abort_state", 32'(dbg_state), 0);
    repeat (40) @(posedge clk);
    check_eq("cont_stop_done_cnt", done_cnt, 3);
    check_eq("cont_stop_clr", clr_cnt, 3);
  endtask
`endif

  // ---------------- main ----------------
  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    clear_counts();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ser_a = 1'b0;
    bus.ser_b = 1'b0;
    do_reset();
    run_plan();
    check_eq("exp_q_drained", 32'(exp_q.size()), 0);
    check_eq("done_q_drained", 32'(done_exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
